// File: rtl/fir_output_quantizer.sv
// Narrows wide signed FIR accumulator sums to OUT_WIDTH samples with saturation and a 2-entry output buffer.
// Define FIR_QUANT_ROUND_EN for round-half-up; otherwise the SHIFT fractional bits are truncated toward -inf.
module fir_output_quantizer #(
    parameter int IN_WIDTH  = 38,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_WIDTH-1:0]        ovf_count,
    output logic                        ovf_flag,
    input  logic                        clr_ovf
);

    localparam int EXT_WIDTH = IN_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EXT_WIDTH-1:0] ext_sum;
    logic signed [EXT_WIDTH-1:0] biased_sum;
    logic signed [EXT_WIDTH-1:0] shifted_sum;
    logic                        sat_pos;
    logic                        sat_neg;
    logic                        ovf_event;
    logic signed [OUT_WIDTH-1:0] quant_data;

    logic                        ready_q;
    logic                        tail_valid;
    logic signed [OUT_WIDTH-1:0] tail_data;
    logic                        push;
    logic                        pop;
    logic [1:0]                  occupancy;
    logic [1:0]                  next_occupancy;

    // One extra bit of headroom so the rounding bias can never wrap the sum.
    assign ext_sum = {in_data[IN_WIDTH-1], in_data};

`ifdef FIR_QUANT_ROUND_EN
    localparam logic [EXT_WIDTH-1:0] HALF_LSB = {{(EXT_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);

    assign biased_sum = ext_sum + $signed(HALF_LSB);
`else
    assign biased_sum = ext_sum;
`endif

    assign shifted_sum = biased_sum >>> SHIFT;

    // In range only when every bit from the output sign bit upward matches the sign.
    assign sat_pos = ~shifted_sum[EXT_WIDTH-1] &  (|shifted_sum[EXT_WIDTH-1:OUT_WIDTH-1]);
    assign sat_neg =  shifted_sum[EXT_WIDTH-1] & ~(&shifted_sum[EXT_WIDTH-1:OUT_WIDTH-1]);

    always_comb begin
        quant_data = shifted_sum[OUT_WIDTH-1:0];
        if (sat_pos) begin
            quant_data = OUT_MAX;
        end else if (sat_neg) begin
            quant_data = OUT_MIN;
        end
    end

    // Ready is masked by reset so it reads low for the whole reset pulse.
    assign in_ready  = ready_q & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ovf_event = push & (sat_pos | sat_neg);

    assign occupancy      = {1'b0, out_valid} + {1'b0, tail_valid};
    assign next_occupancy = occupancy + {1'b0, push} - {1'b0, pop};

    // The head entry lives directly in out_data so it holds after the last pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
        end else begin
            ready_q <= (next_occupancy != 2'd2);
            if (pop) begin
                if (tail_valid) begin
                    out_data   <= tail_data;
                    tail_valid <= push;
                    if (push) begin
                        tail_data <= quant_data;
                    end
                end else if (push) begin
                    out_data <= quant_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (push) begin
                if (!out_valid) begin
                    out_data  <= quant_data;
                    out_valid <= 1'b1;
                end else begin
                    tail_data  <= quant_data;
                    tail_valid <= 1'b1;
                end
            end
        end
    end

    // A clear in the same cycle as an event leaves exactly that one event counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
            ovf_flag  <= 1'b0;
        end else if (ovf_event) begin
            ovf_flag <= 1'b1;
            if (clr_ovf) begin
                ovf_count <= CNT_ONE;
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end else if (clr_ovf) begin
            ovf_count <= '0;
            ovf_flag  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Scoreboard bench for fir_output_quantizer: directed vectors, expected samples queued at accept time.
module tb_fir_output_quantizer;

    localparam int IN_WIDTH  = 38;
    localparam int OUT_WIDTH = 16;
    localparam int SHIFT     = 15;
    localparam int CNT_WIDTH = 16;

`ifdef FIR_QUANT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [CNT_WIDTH-1:0]        ovf_count;
    logic                        ovf_flag;
    logic                        clr_ovf;

    int errors = 0;
    int checks = 0;
    int exp_ovf = 0;
    logic signed [OUT_WIDTH-1:0] exp_q[$];
    logic signed [OUT_WIDTH-1:0] mon_exp;

    fir_output_quantizer #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (SHIFT),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf_count(ovf_count),
        .ovf_flag (ovf_flag),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Holds in_valid until accepted, queueing the expected sample at the accept cycle.
    task automatic applyStimulus(input logic signed [IN_WIDTH-1:0] data,
                                 input logic signed [OUT_WIDTH-1:0] expected);
        int waited = 0;
        in_data  = data;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(expected);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every output transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got %0d, expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("out_data", out_data, mon_exp);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_ovf_count", ovf_count, 0);
        checkOutput("reset_ovf_flag", ovf_flag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] pass-through");
        applyStimulus(38'sd3276800, 16'sd100);
        checkOutput("latency_out_valid", out_valid, 1);
        checkOutput("pass_ovf_count", ovf_count, 0);
        drain();

        $display("[TB] saturation");
        applyStimulus(38'sd2147483648, 16'sd32767);
        exp_ovf = 1;
        checkOutput("sat_pos_count", ovf_count, exp_ovf);
        checkOutput("sat_pos_flag", ovf_flag, 1);
        applyStimulus(-38'sd2147483648, 16'sh8000);
        exp_ovf = 2;
        checkOutput("sat_neg_count", ovf_count, exp_ovf);
        applyStimulus(-38'sd1073741824, 16'sh8000);
        checkOutput("exact_min_count", ovf_count, exp_ovf);
        applyStimulus(38'sd1073741823, 16'sd32767);
        if (ROUND) exp_ovf = exp_ovf + 1;
        checkOutput("edge_carry_count", ovf_count, exp_ovf);
        applyStimulus(38'sh1F_FFFF_FFFF, 16'sd32767);
        applyStimulus(38'sh20_0000_0000, 16'sh8000);
        exp_ovf = exp_ovf + 2;
        checkOutput("extreme_count", ovf_count, exp_ovf);
        checkOutput("extreme_flag", ovf_flag, 1);
        drain();

        $display("[TB] rounding");
        applyStimulus(38'sd16384, ROUND ? 16'sd1 : 16'sd0);
        applyStimulus(-38'sd16384, ROUND ? 16'sd0 : -16'sd1);
        applyStimulus(38'sd16383, 16'sd0);
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(38'sd32768, 16'sd1);
        applyStimulus(38'sd65536, 16'sd2);
        in_data  = 38'sd98304;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_out_valid", out_valid, 1);
        @(negedge clk);
        checkOutput("held_in_ready", in_ready, 0);
        checkOutput("held_out_data", out_data, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(38'sd98304, 16'sd3);
        drain();

        $display("[TB] clear race");
        clr_ovf = 1'b1;
        applyStimulus(38'sd2147483648, 16'sd32767);
        clr_ovf = 1'b0;
        exp_ovf = 1;
        checkOutput("race_count", ovf_count, exp_ovf);
        checkOutput("race_flag", ovf_flag, 1);
        clr_ovf = 1'b1;
        waitCycles(1);
        clr_ovf = 1'b0;
        exp_ovf = 0;
        checkOutput("clear_count", ovf_count, exp_ovf);
        checkOutput("clear_flag", ovf_flag, 0);
        drain();

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(38'sd2147483648, 16'sd32767);
        applyStimulus(38'sd32768, 16'sd1);
        checkOutput("pre_reset_count", ovf_count, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        checkOutput("post_reset_out_valid", out_valid, 0);
        checkOutput("post_reset_count", ovf_count, exp_ovf);
        checkOutput("post_reset_flag", ovf_flag, 0);
        @(negedge clk);
        checkOutput("post_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitCycles(4);
        applyStimulus(38'sd163840, 16'sd5);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
